// File: rtl/ccnet_rx_framer.sv
// CCNET response-frame receiver: SYNC/ADR/LNG/payload/CRC16 assembly with a one-frame hold buffer.
// Optional CCNET_RX_STATS_EN adds saturating good/CRC-error/timeout counters.
module ccnet_rx_framer #(
  parameter int          CLK_HZ       = 10_000_000,
  parameter logic [7:0]  DEV_ADDR     = 8'h03,
  parameter int          MAX_PAYLOAD  = 16,
  parameter int          BYTE_TIMEOUT = 50000
) (
  input  logic       CLK_10MHZ,
  input  logic       RST,
  input  logic [7:0] rxData,
  input  logic       rxDataReady,
  output logic       frameValid,
  output logic [7:0] frameCmd,
  output logic [4:0] frameLen,
  input  logic [3:0] rdAddr,
  output logic [7:0] rdData,
  input  logic       frameAck,
  output logic       crcErr,
  output logic       lenErr,
  output logic       timeoutErr,
  output logic       overrun
`ifdef CCNET_RX_STATS_EN
  ,
  output logic [7:0] statGood,
  output logic [7:0] statCrcErr,
  output logic [7:0] statTimeout
`endif
);

  localparam int TO_W = $clog2(BYTE_TIMEOUT + 1) + ((CLK_HZ > 0) ? 0 : 1);

  typedef enum logic [2:0] {HUNT, ADDR, LEN, PAYLOAD, CRC_LO, CRC_HI, CHECK, HOLD} state_t;

  state_t            state, stateNext;
  logic [1:0]        rxHist_p0;
  logic              byteEvt;
  logic [15:0]       crc, crcStep;
  logic [7:0]        crcSh;
  logic [3:0]        crcBits;
  logic [TO_W-1:0]   toCnt;
  logic [3:0]        idx;
  logic [7:0]        crcLo, crcHi;
  logic [7:0]        buffer [MAX_PAYLOAD];
  logic              crcStart, crcFold, bufWr, lenBad, crcBad, toHit, ovr, frameOk, lenOk, running;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign byteEvt = (rxHist_p0 == 2'b01);
  assign running = (state == ADDR) || (state == LEN) || (state == PAYLOAD) ||
                   (state == CRC_LO) || (state == CRC_HI);
  assign lenOk   = (rxData >= 8'd6) && (rxData <= 8'(MAX_PAYLOAD + 5));

  // Reflected CCITT step, one bit per clock, LSB of the shifted byte first
  always_comb begin
    crcStep = {1'b0, crc[15:1]};
    if (crc[0] ^ crcSh[0]) crcStep = crcStep ^ 16'h8408;
  end

  always_comb begin
    stateNext = state;
    crcStart  = 1'b0;
    crcFold   = 1'b0;
    bufWr     = 1'b0;
    lenBad    = 1'b0;
    crcBad    = 1'b0;
    ovr       = 1'b0;
    frameOk   = 1'b0;
    toHit     = running && !byteEvt && (toCnt == TO_W'(BYTE_TIMEOUT - 1));
    case (state)
      HUNT: if (byteEvt && rxData == 8'h02) begin
        crcStart  = 1'b1;
        crcFold   = 1'b1;
        stateNext = ADDR;
      end
      ADDR: if (toHit) stateNext = HUNT;
        else if (byteEvt) begin
          if (rxData == DEV_ADDR) begin
            crcFold   = 1'b1;
            stateNext = LEN;
          end else stateNext = HUNT;
        end
      LEN: if (toHit) stateNext = HUNT;
        else if (byteEvt) begin
          if (lenOk) begin
            crcFold   = 1'b1;
            stateNext = PAYLOAD;
          end else begin
            lenBad    = 1'b1;
            stateNext = HUNT;
          end
        end
      PAYLOAD: if (toHit) stateNext = HUNT;
        else if (byteEvt) begin
          bufWr   = 1'b1;
          crcFold = 1'b1;
          if ({1'b0, idx} + 5'd1 == frameLen) stateNext = CRC_LO;
        end
      CRC_LO: if (toHit) stateNext = HUNT;
        else if (byteEvt) stateNext = CRC_HI;
      CRC_HI: if (toHit) stateNext = HUNT;
        else if (byteEvt) stateNext = CHECK;
      CHECK: if ({crcHi, crcLo} == crc) begin
          frameOk   = 1'b1;
          stateNext = HOLD;
        end else begin
          crcBad    = 1'b1;
          stateNext = HUNT;
        end
      HOLD: begin
        ovr = byteEvt;
        if (frameAck) stateNext = HUNT;
      end
      default: stateNext = HUNT;
    endcase
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (RST) begin
      state      <= HUNT;
      rxHist_p0  <= 2'b00;
      crc        <= 16'h0000;
      crcBits    <= 4'd0;
      toCnt      <= '0;
      idx        <= 4'd0;
      frameValid <= 1'b0;
      frameCmd   <= 8'h00;
      frameLen   <= 5'd0;
      rdData     <= 8'h00;
      crcErr     <= 1'b0;
      lenErr     <= 1'b0;
      timeoutErr <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= stateNext;
      rxHist_p0  <= {rxHist_p0[0], rxDataReady};
      toCnt      <= (running && !byteEvt && !toHit) ? toCnt + 1'b1 : '0;
      rdData     <= buffer[rdAddr];
      crcErr     <= crcBad;
      lenErr     <= lenBad;
      timeoutErr <= toHit;
      overrun    <= ovr;
      if (crcFold) begin
        crcBits <= 4'd8;
        if (crcStart) crc <= 16'h0000;
      end else if (crcBits != 4'd0) begin
        crc     <= crcStep;
        crcBits <= crcBits - 4'd1;
      end
      if (state == LEN && byteEvt && lenOk) begin
        frameLen <= 5'(rxData - 8'd5);
        idx      <= 4'd0;
      end else if (bufWr) idx <= idx + 4'd1;
      if (frameOk) begin
        frameValid <= 1'b1;
        frameCmd   <= buffer[0];
      end else if (state == HOLD && frameAck) frameValid <= 1'b0;
    end
  end

  // Data-only registers: buffer, CRC shift byte and received CRC bytes carry no reset
  always_ff @(posedge CLK_10MHZ) begin
    if (bufWr) buffer[idx] <= rxData;
    if (crcFold) crcSh <= rxData;
    else if (crcBits != 4'd0) crcSh <= {1'b0, crcSh[7:1]};
    if (state == CRC_LO && byteEvt) crcLo <= rxData;
    if (state == CRC_HI && byteEvt) crcHi <= rxData;
  end

`ifdef CCNET_RX_STATS_EN
  always_ff @(posedge CLK_10MHZ) begin
    if (RST) begin
      statGood    <= 8'h00;
      statCrcErr  <= 8'h00;
      statTimeout <= 8'h00;
    end else begin
      if (frameOk) statGood    <= satInc(statGood);
      if (crcBad)  statCrcErr  <= satInc(statCrcErr);
      if (toHit)   statTimeout <= satInc(statTimeout);
    end
  end
`endif

endmodule

// File: tb/tb_ccnet_rx_framer.sv
// Scoreboard bench for ccnet_rx_framer: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_ccnet_rx_framer;

  localparam int EV_FRAME = 0, EV_CRC = 1, EV_LEN = 2, EV_TO = 3, EV_OVR = 4;

  typedef struct {
    int         kind;
    logic [7:0] cmd;
    logic [4:0] len;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rxData = 8'h00;
  logic       rxDataReady = 1'b0;
  logic [3:0] rdAddr = 4'd0;
  logic       frameAck = 1'b0;
  logic       frameValid, crcErr, lenErr, timeoutErr, overrun;
  logic [7:0] frameCmd, rdData;
  logic [4:0] frameLen;
`ifdef CCNET_RX_STATS_EN
  logic [7:0] statGood, statCrcErr, statTimeout;
`endif

  int  errors = 0;
  int  checks = 0;
  ev_t sbq[$];
  logic prevFv = 1'b0;

  ccnet_rx_framer dut (
    .CLK_10MHZ(clk), .RST(rst), .rxData(rxData), .rxDataReady(rxDataReady),
    .frameValid(frameValid), .frameCmd(frameCmd), .frameLen(frameLen),
    .rdAddr(rdAddr), .rdData(rdData), .frameAck(frameAck),
    .crcErr(crcErr), .lenErr(lenErr), .timeoutErr(timeoutErr), .overrun(overrun)
`ifdef CCNET_RX_STATS_EN
    , .statGood(statGood), .statCrcErr(statCrcErr), .statTimeout(statTimeout)
`endif
  );

  always #50 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] cmd, input logic [4:0] len);
    ev_t e;
    e.kind = kind; e.cmd = cmd; e.len = len;
    sbq.push_back(e);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = sbq.pop_front();
      chk("event_kind", 16'(kind), 16'(e.kind));
      if (kind == EV_FRAME && e.kind == EV_FRAME) begin
        chk("frame_cmd", {8'h0, frameCmd}, {8'h0, e.cmd});
        chk("frame_len", {11'h0, frameLen}, {11'h0, e.len});
      end
    end
  endtask

  // Monitor: every output event is matched against the scoreboard head
  always @(negedge clk) begin
    if (frameValid && !prevFv) observe(EV_FRAME);
    if (crcErr)     observe(EV_CRC);
    if (lenErr)     observe(EV_LEN);
    if (timeoutErr) observe(EV_TO);
    if (overrun)    observe(EV_OVR);
    prevFv = frameValid;
  end

  task automatic sendByte(input logic [7:0] b);
    rxData = b;
    @(posedge clk); #1 rxDataReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rxDataReady = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  // Byte whose event cycle coincides with a one-cycle frameAck
  task automatic sendByteAck(input logic [7:0] b);
    rxData = b;
    @(posedge clk); #1 rxDataReady = 1'b1;
    @(posedge clk); #1 frameAck = 1'b1;
    @(posedge clk); #1 frameAck = 1'b0;
    @(posedge clk); #1 rxDataReady = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic sendSeq(input logic [7:0] b [], input int n);
    for (int i = 0; i < n; i++) sendByte(b[i]);
  endtask

  task automatic ack();
    @(posedge clk); #1 frameAck = 1'b1;
    @(posedge clk); #1 frameAck = 1'b0;
  endtask

  function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic sendFrameN(input int n);
    logic [15:0] c;
    logic [7:0]  lng;
    lng = 8'(n + 5);
    c = crcByte(16'h0000, 8'h02);
    c = crcByte(c, 8'h03);
    c = crcByte(c, lng);
    sendByte(8'h02); sendByte(8'h03); sendByte(lng);
    for (int i = 0; i < n; i++) begin
      c = crcByte(c, 8'hA0 + 8'(i));
      sendByte(8'hA0 + 8'(i));
    end
    sendByte(c[7:0]); sendByte(c[15:8]);
  endtask

  task automatic drain(input int budget, input string nm);
    int k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(posedge clk); k++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending events expected 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic checkIdleOutputs(input string nm);
    chk({nm, "_frameValid"}, {15'h0, frameValid}, 16'h0);
    chk({nm, "_frameCmd"},   {8'h0, frameCmd},    16'h0);
    chk({nm, "_frameLen"},   {11'h0, frameLen},   16'h0);
    chk({nm, "_rdData"},     {8'h0, rdData},      16'h0);
    chk({nm, "_pulses"},     {12'h0, crcErr, lenErr, timeoutErr, overrun}, 16'h0);
  endtask

  initial begin
    logic [7:0] good [] = '{8'h02, 8'h03, 8'h06, 8'h00, 8'hC2, 8'h82};
    logic [7:0] ill  [] = '{8'h02, 8'h03, 8'h06, 8'h30, 8'h41, 8'hB3};
    logic [7:0] bad  [] = '{8'h02, 8'h03, 8'h06, 8'h00, 8'hC2, 8'h83};
    logic [7:0] wadr [] = '{8'h02, 8'h05, 8'h06, 8'h00, 8'hC2, 8'h82};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    #1 rst = 1'b0;

    // Minimal valid frame, readback and release
    expect_ev(EV_FRAME, 8'h00, 5'd1);
    sendSeq(good, 6);
    drain(50, "frame1");
    chk("frame1_valid", {15'h0, frameValid}, 16'h1);
    rdAddr = 4'd0;
    @(posedge clk); #1;
    chk("frame1_rd0", {8'h0, rdData}, 16'h00);
    ack();
    chk("frame1_released", {15'h0, frameValid}, 16'h0);

    // Ignored ack while idle, then held frame with overruns; last byte collides with ack
    ack();
    expect_ev(EV_FRAME, 8'h30, 5'd1);
    sendSeq(ill, 6);
    drain(50, "frame2");
    expect_ev(EV_OVR, 8'h00, 5'd0);
    expect_ev(EV_OVR, 8'h00, 5'd0);
    sendByte(8'h02); sendByte(8'h55);
    drain(50, "overrun12");
    chk("held_valid", {15'h0, frameValid}, 16'h1);
    chk("held_cmd",   {8'h0, frameCmd},    16'h30);
    chk("held_len",   {11'h0, frameLen},   16'h1);
    chk("held_rd0",   {8'h0, rdData},      16'h30);
    expect_ev(EV_OVR, 8'h00, 5'd0);
    sendByteAck(8'hAA);
    drain(50, "overrun3");
    chk("ack_with_byte_released", {15'h0, frameValid}, 16'h0);

    // CRC error then resync
    expect_ev(EV_CRC, 8'h00, 5'd0);
    sendSeq(bad, 6);
    drain(50, "crcerr");
    chk("crcerr_novalid", {15'h0, frameValid}, 16'h0);
    expect_ev(EV_FRAME, 8'h00, 5'd1);
    sendSeq(good, 6);
    drain(50, "resync");
    ack();

    // Inter-byte timeout, then a good frame
    expect_ev(EV_TO, 8'h00, 5'd0);
    sendByte(8'h02); sendByte(8'h03);
    drain(60000, "timeout");
    repeat (200) @(posedge clk);
    expect_ev(EV_FRAME, 8'h00, 5'd1);
    sendSeq(good, 6);
    drain(50, "after_timeout");
    ack();

    // Length limits and address mismatch
    expect_ev(EV_LEN, 8'h00, 5'd0);
    sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    drain(50, "len_short");
    expect_ev(EV_LEN, 8'h00, 5'd0);
    sendByte(8'h02); sendByte(8'h03); sendByte(8'h20);
    drain(50, "len_long");
    expect_ev(EV_LEN, 8'h00, 5'd0);
    sendByte(8'h02); sendByte(8'h03); sendByte(8'h16);
    drain(50, "len_17");
    sendSeq(wadr, 6);
    repeat (30) @(posedge clk);
    chk("wrong_addr_novalid", {15'h0, frameValid}, 16'h0);

    // Full-depth payload and registered read latency
    expect_ev(EV_FRAME, 8'hA0, 5'd16);
    sendFrameN(16);
    drain(50, "frame16");
    rdAddr = 4'd15;
    @(posedge clk); #1;
    chk("rd15", {8'h0, rdData}, 16'hAF);
    rdAddr = 4'd5;
    #5;
    chk("rd_latency_old", {8'h0, rdData}, 16'hAF);
    @(posedge clk); #1;
    chk("rd5", {8'h0, rdData}, 16'hA5);
    ack();

    // Reset mid-frame abandons it
    sendByte(8'h02); sendByte(8'h03); sendByte(8'h06); sendByte(8'h00);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("midreset");
    #1 rst = 1'b0;
    sendByte(8'hC2); sendByte(8'h82);
    repeat (30) @(posedge clk);
    chk("midreset_novalid", {15'h0, frameValid}, 16'h0);
    drain(10, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
